instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of the decode stage and its ControlUnit. Holds the PC, drives the instruction-memory address and registers the IF/ID pipeline latch consumed by decode. It also consumes decode/execute redirect and halt information: Jump and Halt come from ID, and the resolved branch comes from EX.

Parameters:
ADDR_W, 32, PC and address width in bits
PC_RESET, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of the run-cycle counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
i_stall  input  1  load-use hazard stall from hazard unit; hold PC and IF/ID
i_branch_taken  input  1  EX-resolved branch taken (Branch & condition per TipoBranch)
i_branch_target  input  ADDR_W  branch target address from EX
i_jump  input  1  Jump decoded for the instruction currently in IF/ID
i_jump_index  input  26  instr[25:0] of that jump
i_halt  input  1  Halt decoded for the instruction currently in IF/ID
o_imem_addr  output  ADDR_W  instruction-memory address (equals PC), combinational-read memory
i_imem_data  input  32  instruction word at o_imem_addr, same cycle
o_ifid_instr  output  32  IF/ID instruction register
o_ifid_pc4  output  ADDR_W  IF/ID PC+4 register
o_ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)
o_flush  output  1  combinational; i_branch_taken | i_jump (accepted); downstream squashes ID/EX
o_halted  output  1  stage is in HALTED state
o_cycle_count  output  CNT_W  cycles spent in RUN since reset

Behaviour:
- Reset (async, immediate): PC=PC_RESET, o_ifid_instr=0 (NOP), o_ifid_pc4=0, o_ifid_valid=0, o_halted=0, o_cycle_count=0, state=RUN.
- States: RUN, HALTED. RUN->HALTED when the halt is accepted. HALTED exits only on reset.
- i_jump and i_halt are accepted only when o_ifid_valid=1.
- Per-cycle priority in RUN, highest first:
  1. i_branch_taken: PC<=i_branch_target; IF/ID<=bubble (instr 0, valid 0). Any same-cycle jump/halt is ignored (wrong-path instruction).
  2. accepted i_jump: PC<={o_ifid_pc4[31:28], i_jump_index, 2'b00}; IF/ID<=bubble. No delay slot.
  3. accepted i_halt: state<=HALTED; PC holds; IF/ID<=bubble. Wins over i_stall.
  4. i_stall: PC and all IF/ID registers hold.
  5. otherwise: IF/ID<={i_imem_data, PC+4, valid=1}; PC<=PC+4.
- PC+4 wraps modulo 2^ADDR_W; PC[1:0] is never forced and is passed through unchanged.
- HALTED: PC frozen, IF/ID holds bubble, all inputs ignored, o_flush=0, counter frozen.
- o_cycle_count increments by 1 on every RUN cycle, including stalled cycles and the cycle the halt is accepted, and wraps at 2^CNT_W.
- Latency: an instruction fetched at PC in cycle n appears in IF/ID at cycle n+1.
- o_flush is asserted whenever priority 1 or 2 is taken and is 0 during reset.

Optional Feature:
DEBUG_STEP_EN:
- Defined: adds input i_step (1 bit) and input i_step_mode (1 bit). When i_step_mode=1, the priority-5 advance happens only on a cycle with i_step=1 (one instruction per pulse); otherwise it behaves like a stall. Redirects and halt still act immediately. The counter counts only advance cycles.
- Undefined: ports absent; behaviour as above.

Test Plan:
- Reset then run, imem[0]=0x2001_0005, imem[4]=0x2002_0003 -> cycle 1 IF/ID={0x20010005, pc4=4, valid=1}; cycle 2 pc4=8; o_cycle_count=2.
- i_stall=1 for 3 cycles at PC=0x8 -> PC and IF/ID unchanged for 3 cycles; resumes at 0xC on release; counter +3 during the stall.
- IF/ID pc4=0x1000_0010, i_jump=1, i_jump_index=0x000_0040 -> PC=0x1000_0100, IF/ID bubble, o_flush=1 for one cycle.
- i_branch_taken=1, target=0x40 with i_jump=1 and i_halt=1 the same cycle -> PC=0x40, stays RUN, bubble inserted.
- i_halt=1 with o_ifid_valid=1 and i_stall=1 -> o_halted=1 next cycle; PC, IF/ID bubble and counter frozen for 10+ cycles; async reset mid-cycle restores PC=0 and state RUN.
- PC=0xFFFF_FFFC sequential fetch -> next PC=0x0000_0000, o_ifid_pc4=0x0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC, instruction-memory address and IF/ID latch.
// Optional single-step debug mode is enabled by defining DEBUG_STEP_EN.
module instruction_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_jump,
    input  logic [25:0]       i_jump_index,
    input  logic              i_halt,
`ifdef DEBUG_STEP_EN
    input  logic              i_step,
    input  logic              i_step_mode,
`endif
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_data,
    output logic [31:0]       o_ifid_instr,
    output logic [ADDR_W-1:0] o_ifid_pc4,
    output logic              o_ifid_valid,
    output logic              o_flush,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_cycle_count
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_seq;
    logic [ADDR_W-1:0] jump_target;
    logic              jump_ok;
    logic              halt_ok;
    logic              advance;
    logic              count_en;

    assign pc_next_seq = pc + ADDR_W'(4);
    assign jump_target = {o_ifid_pc4[ADDR_W-1:28], i_jump_index, 2'b00};
    // Jump/halt belong to the instruction in IF/ID, so a bubble cannot raise them.
    assign jump_ok     = i_jump & o_ifid_valid;
    assign halt_ok     = i_halt & o_ifid_valid;

`ifdef DEBUG_STEP_EN
    assign advance  = ~i_step_mode | i_step;
    assign count_en = advance;
`else
    assign advance  = 1'b1;
    assign count_en = 1'b1;
`endif

    assign o_imem_addr = pc;
    assign o_halted    = (state == HALTED);
    assign o_flush     = ~reset & (state == RUN) & (i_branch_taken | jump_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            pc            <= PC_RESET;
            o_ifid_instr  <= '0;
            o_ifid_pc4    <= '0;
            o_ifid_valid  <= 1'b0;
            o_cycle_count <= '0;
        end else if (state == RUN) begin
            if (count_en) begin
                o_cycle_count <= o_cycle_count + CNT_W'(1);
            end
            if (i_branch_taken) begin
                pc           <= i_branch_target;
                o_ifid_instr <= '0;
                o_ifid_valid <= 1'b0;
            end else if (jump_ok) begin
                pc           <= jump_target;
                o_ifid_instr <= '0;
                o_ifid_valid <= 1'b0;
            end else if (halt_ok) begin
                state        <= HALTED;
                o_ifid_instr <= '0;
                o_ifid_valid <= 1'b0;
            end else if (!i_stall && advance) begin
                pc           <= pc_next_seq;
                o_ifid_instr <= i_imem_data;
                o_ifid_pc4   <= pc_next_seq;
                o_ifid_valid <= 1'b1;
            end
        end
    end

endmodule
